mc_control_fsm: RTL and testbench

- Moore-style control state machine for the multicycle processor datapath.
- Sequences fetch, decode, execute, memory and write-back over multiple cycles.
- Drives the write enables of the PC, IR and register-file DFF banks, plus the mux and ALU selects.
- Stretches memory states with a MemReady handshake. Sits beside the datapath top and is fed by IR[31:26].

---
 rtl/mc_control_fsm_pkg.sv | 70 +++++++
 rtl/mc_control_fsm_if.sv | 39 +++
 rtl/mc_ctrl_decode.sv | 71 +++++++
 rtl/mc_control_fsm.sv | 104 ++++++++++
 tb/tb_mc_control_fsm.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared constants and types for the multicycle controller and its datapath:
// state codes, opcodes, mux/ALU select codes and the control-vector bundle.
package mc_pkg;

  localparam int unsigned OpWidth = 6;

  // State codes are visible on the debug port, so values are fixed.
  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11
  } state_e;

  // Opcodes taken from IR[31:26].
  localparam logic [OpWidth-1:0] OpRtype = 6'b000000;
  localparam logic [OpWidth-1:0] OpLw    = 6'b100011;
  localparam logic [OpWidth-1:0] OpSw    = 6'b101011;
  localparam logic [OpWidth-1:0] OpBeq   = 6'b000100;
  localparam logic [OpWidth-1:0] OpJ     = 6'b000010;
  localparam logic [OpWidth-1:0] OpAddi  = 6'b001000;

  // ALU operation select.
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // ALU B operand select.
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // Next-PC source select.
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // Full set of datapath controls produced for one state.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // True for opcodes that DECODE knows how to dispatch.
  function automatic logic op_is_legal(logic [OpWidth-1:0] op);
    return (op == OpRtype) || (op == OpLw) || (op == OpSw) ||
           (op == OpBeq) || (op == OpJ) || (op == OpAddi);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface mc_control_fsm_if #(
  parameter int unsigned OpW = 6
) ();

  logic [OpW-1:0] op;
  logic           mem_ready;

  logic           pc_write;
  logic           pc_write_cond;
  logic           iord;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           mem_to_reg;
  logic           reg_dst;
  logic           reg_write;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     alu_op;
  logic [1:0]     pc_source;
  logic           illegal;
  logic [3:0]     state;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal, state
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal, state
  );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Pure state-to-control decoder. FETCH reports ungated IR/PC writes; the parent
// applies the MemReady gating and reset forcing.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_e state_i,
  output ctrl_t  ctrl_o
);

  // Per-state control vector; everything not named for a state stays 0.
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SrcBFour;
        ctrl_o.alu_op    = AluOpAdd;
        ctrl_o.pc_source = PcSrcAlu;
      end
      StDecode: begin
        // Branch target is computed speculatively here.
        ctrl_o.alu_src_b = SrcBImmSh;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemAddr, StAddiEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemRd: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      StExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBReg;
        ctrl_o.alu_op    = AluOpFunct;
      end
      StRWb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SrcBReg;
        ctrl_o.alu_op        = AluOpSub;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PcSrcAluOut;
      end
      StJump: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PcSrcJump;
      end
      StAddiWb: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multicycle datapath: state register, next-state
// logic, MemReady stretching and reset gating of all write enables.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int unsigned OpW         = OpWidth,
  parameter bit          UseMemReady = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mc_control_fsm_if.master   ctrl_if
);

  state_e         state_q, state_d;
  state_e         dec_state;
  ctrl_t          ctrl_raw;
  ctrl_t          ctrl_out;
  logic           mem_rdy;
  logic           illegal_d;
  logic [OpW-1:0] op;

  assign op      = ctrl_if.op;
  assign mem_rdy = UseMemReady ? ctrl_if.mem_ready : 1'b1;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection; Op is only consulted in DECODE and MEM_ADDR.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    unique case (state_q)
      StFetch: if (mem_rdy) state_d = StDecode;
      StDecode: begin
        case (op)
          OpRtype:    state_d = StExec;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
          default: begin
            state_d   = StFetch;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAddr: state_d = (op == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (mem_rdy) state_d = StMemWb;
      StMemWr:   if (mem_rdy) state_d = StFetch;
      StExec:    state_d = StRWb;
      StAddiEx:  state_d = StAddiWb;
      StMemWb, StRWb, StAddiWb, StBranch, StJump: state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  // While in reset the selects show the FETCH pattern regardless of state_q.
  assign dec_state = rst_i ? StFetch : state_q;

  mc_ctrl_decode u_decode (
    .state_i (dec_state),
    .ctrl_o  (ctrl_raw)
  );

  // FETCH write gating on MemReady, and reset kills every enable.
  always_comb begin
    ctrl_out = ctrl_raw;
    if (dec_state == StFetch) begin
      ctrl_out.ir_write = ctrl_raw.ir_write & mem_rdy;
      ctrl_out.pc_write = ctrl_raw.pc_write & mem_rdy;
    end
    if (rst_i) begin
      ctrl_out.pc_write      = 1'b0;
      ctrl_out.pc_write_cond = 1'b0;
      ctrl_out.mem_read      = 1'b0;
      ctrl_out.mem_write     = 1'b0;
      ctrl_out.ir_write      = 1'b0;
      ctrl_out.reg_write     = 1'b0;
    end
  end

  assign ctrl_if.pc_write      = ctrl_out.pc_write;
  assign ctrl_if.pc_write_cond = ctrl_out.pc_write_cond;
  assign ctrl_if.iord          = ctrl_out.iord;
  assign ctrl_if.mem_read      = ctrl_out.mem_read;
  assign ctrl_if.mem_write     = ctrl_out.mem_write;
  assign ctrl_if.ir_write      = ctrl_out.ir_write;
  assign ctrl_if.mem_to_reg    = ctrl_out.mem_to_reg;
  assign ctrl_if.reg_dst       = ctrl_out.reg_dst;
  assign ctrl_if.reg_write     = ctrl_out.reg_write;
  assign ctrl_if.alu_src_a     = ctrl_out.alu_src_a;
  assign ctrl_if.alu_src_b     = ctrl_out.alu_src_b;
  assign ctrl_if.alu_op        = ctrl_out.alu_op;
  assign ctrl_if.pc_source     = ctrl_out.pc_source;
  assign ctrl_if.illegal       = illegal_d & ~rst_i;
  assign ctrl_if.state         = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: each stimulus cycle pushes the expected
// state and control vector; a negedge monitor pops and compares.
module tb_mc_control_fsm;

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    int          idx;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc_idx  = 0;

  mc_control_fsm_if #(.OpW(6)) ctrl_if ();

  mc_control_fsm dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .ctrl_if (ctrl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for one cycle, written from the state output table.
  // Vector: pcw,pcc,iord,mrd,mwr,irw,m2r,rdst,rw,asa,srcb[2],aluop[2],pcsrc[2],illegal
  function automatic logic [16:0] spec_ctl(int st, bit mr, bit rs, bit ill);
    logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
    logic [1:0] srcb, aop, psrc;
    int s;
    {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa} = '0;
    srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    s = rs ? 0 : st;
    case (s)
      0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      1:  srcb = 2'b11;
      2, 10: begin asa = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; end
      9:  begin pcw = 1; psrc = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    if (rs) {pcw, pcc, mrd, mwr, irw, rw} = '0;
    return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, srcb, aop, psrc, ill && !rs};
  endfunction

  // One clock of stimulus with the state expected to be visible during it.
  task automatic cyc(input bit rs, input logic [5:0] op, input bit mr, input int st,
                     input bit ill = 1'b0);
    exp_t e;
    rst               = rs;
    ctrl_if.op        = op;
    ctrl_if.mem_ready = mr;
    e.st  = st[3:0];
    e.ctl = spec_ctl(st, mr, rs, ill);
    e.idx = cyc_idx;
    exp_q.push_back(e);
    cyc_idx++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: the controller presents a new vector every cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [16:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {ctrl_if.pc_write, ctrl_if.pc_write_cond, ctrl_if.iord, ctrl_if.mem_read,
             ctrl_if.mem_write, ctrl_if.ir_write, ctrl_if.mem_to_reg, ctrl_if.reg_dst,
             ctrl_if.reg_write, ctrl_if.alu_src_a, ctrl_if.alu_src_b, ctrl_if.alu_op,
             ctrl_if.pc_source, ctrl_if.illegal};
      n_checks++;
      if (ctrl_if.state === e.st) n_pass++;
      else $display("FAIL state cycle %0d: got %0d want %0d", e.idx, ctrl_if.state, e.st);
      n_checks++;
      if (act === e.ctl) n_pass++;
      else $display("FAIL ctrl cycle %0d: got %b want %b", e.idx, act, e.ctl);
    end
  end

  initial begin
    rst               = 1'b1;
    ctrl_if.op        = RT;
    ctrl_if.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held two cycles, then first fetch.
    cyc(1, RT, 1, 0);
    cyc(1, RT, 1, 0);

    // R-type; Op wiggles in EXEC without effect.
    cyc(0, RT, 1, 0);
    cyc(0, RT, 1, 1);
    cyc(0, JMP, 1, 6);
    cyc(0, BAD, 1, 7);

    // lw with 2 FETCH and 3 MEM_RD wait states.
    cyc(0, LW, 0, 0);
    cyc(0, LW, 0, 0);
    cyc(0, LW, 1, 0);
    cyc(0, LW, 1, 1);
    cyc(0, LW, 1, 2);
    cyc(0, LW, 0, 3);
    cyc(0, LW, 0, 3);
    cyc(0, LW, 0, 3);
    cyc(0, LW, 1, 3);
    cyc(0, LW, 1, 4);

    // sw
    cyc(0, SW, 1, 0);
    cyc(0, SW, 1, 1);
    cyc(0, SW, 1, 2);
    cyc(0, SW, 1, 5);

    // beq
    cyc(0, BEQ, 1, 0);
    cyc(0, BEQ, 1, 1);
    cyc(0, BEQ, 1, 8);

    // j
    cyc(0, JMP, 1, 0);
    cyc(0, JMP, 1, 1);
    cyc(0, JMP, 1, 9);

    // addi
    cyc(0, ADDI, 1, 0);
    cyc(0, ADDI, 1, 1);
    cyc(0, ADDI, 1, 10);
    cyc(0, ADDI, 1, 11);

    // Illegal opcode: one Illegal cycle in DECODE, straight back to FETCH.
    cyc(0, BAD, 1, 0);
    cyc(0, BAD, 1, 1, 1'b1);

    // sw stalled in MEM_WR, then reset aborts it.
    cyc(0, SW, 1, 0);
    cyc(0, SW, 1, 1);
    cyc(0, SW, 1, 2);
    cyc(0, SW, 0, 5);
    cyc(1, SW, 0, 5);
    cyc(0, RT, 1, 0);
    cyc(0, RT, 1, 1);
    cyc(0, RT, 1, 6);
    cyc(0, RT, 1, 7);
    cyc(0, RT, 0, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
